// File: rtl/afu_command_arbiter.sv
// rtl/afu_command_arbiter.sv - N-channel PSL command arbiter with tag tracking and credit accounting

module afu_command_arbiter #(
    parameter int NUM_CHANNELS  = 4,
    parameter int PAYLOAD_WIDTH = 89,
    parameter int TAG_WIDTH     = 8,
    parameter int MAX_CREDITS   = 64,
    parameter int ARB_MODE      = 0
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    enabled_in,
    input  logic [NUM_CHANNELS-1:0]                 req_valid,
    input  logic [NUM_CHANNELS*PAYLOAD_WIDTH-1:0]   req_payload,
    output logic [NUM_CHANNELS-1:0]                 req_ready,
    input  logic                                    credit_load,
    input  logic [7:0]                              credit_value,
    output logic                                    cmd_valid,
    output logic [PAYLOAD_WIDTH-1:0]                cmd_payload,
    output logic [TAG_WIDTH-1:0]                    cmd_tag,
    output logic [$clog2(NUM_CHANNELS)-1:0]         cmd_channel,
    input  logic                                    rsp_valid,
    input  logic [TAG_WIDTH-1:0]                    rsp_tag,
    input  logic [8:0]                              rsp_credits,
    output logic [NUM_CHANNELS-1:0]                 rsp_route,
    output logic [TAG_WIDTH-1:0]                    rsp_tag_out,
    output logic [7:0]                              credit_count,
    output logic [TAG_WIDTH:0]                      outstanding,
    output logic                                    credit_overflow_error,
    output logic                                    tag_error
);

    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int DEPTH = 1 << TAG_WIDTH;
    localparam logic signed [9:0] MAX_CREDITS_S = 10'(MAX_CREDITS);

    // tag table: busy bit and owning channel per tag
    logic [DEPTH-1:0]           r_in_use;
    logic [CH_W-1:0]            r_owner [DEPTH];
    logic [TAG_WIDTH-1:0]       r_next_tag;
    logic [CH_W-1:0]            r_last_grant;
    logic [7:0]                 r_credit;
    logic [TAG_WIDTH:0]         r_outstanding;
    logic                       r_cmd_valid;
    logic [PAYLOAD_WIDTH-1:0]   r_cmd_payload;
    logic [TAG_WIDTH-1:0]       r_cmd_tag;
    logic [CH_W-1:0]            r_cmd_channel;
    logic [NUM_CHANNELS-1:0]    r_rsp_route;
    logic [TAG_WIDTH-1:0]       r_rsp_tag_out;
    logic                       r_credit_err;
    logic                       r_tag_err;

    logic [CH_W-1:0]            w_grant_idx;
    logic                       w_grant_found;
    int                         w_rr_sum;
    logic [CH_W-1:0]            w_rr_idx;
    logic [NUM_CHANNELS-1:0]    w_grant_onehot;
    logic [PAYLOAD_WIDTH-1:0]   w_grant_payload;
    logic [NUM_CHANNELS-1:0]    w_rsp_onehot;
    logic                       w_issue_ok;
    logic                       w_transfer;
    logic                       w_rsp_hit;
    logic signed [9:0]          w_credit_delta;
    logic signed [9:0]          w_credit_sum;
    logic [7:0]                 w_credit_next;
    logic                       w_credit_err;

    // pick a winner; loops run farthest-first so the nearest candidate overwrites
    always_comb begin
        w_grant_idx   = '0;
        w_grant_found = 1'b0;
        w_rr_sum      = 0;
        w_rr_idx      = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    w_grant_found = 1'b1;
                    w_grant_idx   = CH_W'(i);
                end
            end
        end else begin
            for (int i = NUM_CHANNELS; i >= 1; i--) begin
                w_rr_sum = int'(r_last_grant) + i;
                if (w_rr_sum >= NUM_CHANNELS) begin
                    w_rr_sum = w_rr_sum - NUM_CHANNELS;
                end
                w_rr_idx = CH_W'(w_rr_sum);
                if (req_valid[w_rr_idx]) begin
                    w_grant_found = 1'b1;
                    w_grant_idx   = w_rr_idx;
                end
            end
        end
    end

    // decode the winner and the response owner into one-hot vectors, select payload
    always_comb begin
        w_grant_onehot  = '0;
        w_grant_payload = '0;
        w_rsp_onehot    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_grant_idx == CH_W'(i)) begin
                w_grant_onehot[i] = 1'b1;
                w_grant_payload   = req_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
            if (r_owner[rsp_tag] == CH_W'(i)) begin
                w_rsp_onehot[i] = 1'b1;
            end
        end
    end

    // strict sequential tag allocation: a busy next tag stalls everything
    assign w_issue_ok = enabled_in & (r_credit != 8'd0) & ~r_in_use[r_next_tag] & w_grant_found;
    assign req_ready  = w_issue_ok ? w_grant_onehot : '0;
    assign w_transfer = |(req_valid & req_ready);
    assign w_rsp_hit  = rsp_valid & r_in_use[rsp_tag];

    // net credit change in 10-bit signed, clamped to [0, MAX_CREDITS]
    always_comb begin
        w_credit_delta = rsp_valid ? $signed({rsp_credits[8], rsp_credits}) : 10'sd0;
        w_credit_sum   = $signed({2'b00, r_credit}) + w_credit_delta - (w_transfer ? 10'sd1 : 10'sd0);
        w_credit_next  = w_credit_sum[7:0];
        w_credit_err   = 1'b0;
        if (w_credit_sum > MAX_CREDITS_S) begin
            w_credit_next = 8'(MAX_CREDITS);
            w_credit_err  = 1'b1;
        end else if (w_credit_sum < 10'sd0) begin
            w_credit_next = 8'd0;
            w_credit_err  = 1'b1;
        end
    end

    // issue, tag bookkeeping, credit accounting, response routing and sticky errors
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_use      <= '0;
            r_next_tag    <= '0;
            r_last_grant  <= CH_W'(NUM_CHANNELS - 1);
            r_credit      <= '0;
            r_outstanding <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_payload <= '0;
            r_cmd_tag     <= '0;
            r_cmd_channel <= '0;
            r_rsp_route   <= '0;
            r_rsp_tag_out <= '0;
            r_credit_err  <= 1'b0;
            r_tag_err     <= 1'b0;
        end else begin
            r_cmd_valid <= w_transfer;
            if (w_transfer) begin
                r_cmd_payload        <= w_grant_payload;
                r_cmd_tag            <= r_next_tag;
                r_cmd_channel        <= w_grant_idx;
                r_next_tag           <= r_next_tag + 1'b1;
                r_last_grant         <= w_grant_idx;
                r_in_use[r_next_tag] <= 1'b1;
            end
            // placed after the set so a clear of the same tag wins
            if (w_rsp_hit) begin
                r_in_use[rsp_tag] <= 1'b0;
            end
            r_outstanding <= r_outstanding + {{TAG_WIDTH{1'b0}}, w_transfer}
                                           - {{TAG_WIDTH{1'b0}}, w_rsp_hit};
            if (credit_load) begin
                r_credit <= credit_value;
            end else begin
                r_credit <= w_credit_next;
                if (w_credit_err) begin
                    r_credit_err <= 1'b1;
                end
            end
            r_rsp_route   <= w_rsp_hit ? w_rsp_onehot : '0;
            r_rsp_tag_out <= rsp_valid ? rsp_tag : '0;
            if (rsp_valid && !w_rsp_hit) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    // owner table needs no reset: it is only read for tags whose busy bit is set
    always_ff @(posedge clock) begin
        if (w_transfer) begin
            r_owner[r_next_tag] <= w_grant_idx;
        end
    end

    assign cmd_valid             = r_cmd_valid;
    assign cmd_payload           = r_cmd_payload;
    assign cmd_tag               = r_cmd_tag;
    assign cmd_channel           = r_cmd_channel;
    assign rsp_route             = r_rsp_route;
    assign rsp_tag_out           = r_rsp_tag_out;
    assign credit_count          = r_credit;
    assign outstanding           = r_outstanding;
    assign credit_overflow_error = r_credit_err;
    assign tag_error             = r_tag_err;

endmodule

// File: tb/tb_afu_command_arbiter.sv
// tb/tb_afu_command_arbiter.sv - model-checked bench for afu_command_arbiter (round-robin and fixed-priority instances)

module tb_afu_command_arbiter;

    logic        clock        = 1'b0;
    logic        reset        = 1'b1;
    logic        enabled_in   = 1'b0;
    logic [3:0]  req_valid    = '0;
    logic [63:0] req_payload  = '0;
    logic        credit_load  = 1'b0;
    logic [7:0]  credit_value = '0;
    logic        rsp_valid    = 1'b0;
    logic [2:0]  rsp_tag      = '0;
    logic [8:0]  rsp_credits  = '0;

    logic [3:0]  rr_req_ready, fp_req_ready;
    logic        rr_cmd_valid, fp_cmd_valid;
    logic [15:0] rr_cmd_payload, fp_cmd_payload;
    logic [2:0]  rr_cmd_tag;
    logic [1:0]  fp_cmd_tag;
    logic [1:0]  rr_cmd_channel, fp_cmd_channel;
    logic [3:0]  rr_rsp_route, fp_rsp_route;
    logic [2:0]  rr_rsp_tag_out;
    logic [1:0]  fp_rsp_tag_out;
    logic [7:0]  rr_credit_count, fp_credit_count;
    logic [3:0]  rr_outstanding;
    logic [2:0]  fp_outstanding;
    logic        rr_cerr, fp_cerr, rr_terr, fp_terr;

    int n_checks = 0;
    int n_fail   = 0;

    afu_command_arbiter #(.NUM_CHANNELS(4), .PAYLOAD_WIDTH(16), .TAG_WIDTH(3),
                          .MAX_CREDITS(64), .ARB_MODE(0)) u_rr (
        .clock(clock), .reset(reset), .enabled_in(enabled_in),
        .req_valid(req_valid), .req_payload(req_payload), .req_ready(rr_req_ready),
        .credit_load(credit_load), .credit_value(credit_value),
        .cmd_valid(rr_cmd_valid), .cmd_payload(rr_cmd_payload), .cmd_tag(rr_cmd_tag),
        .cmd_channel(rr_cmd_channel), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .rsp_credits(rsp_credits), .rsp_route(rr_rsp_route), .rsp_tag_out(rr_rsp_tag_out),
        .credit_count(rr_credit_count), .outstanding(rr_outstanding),
        .credit_overflow_error(rr_cerr), .tag_error(rr_terr));

    afu_command_arbiter #(.NUM_CHANNELS(4), .PAYLOAD_WIDTH(16), .TAG_WIDTH(2),
                          .MAX_CREDITS(64), .ARB_MODE(1)) u_fp (
        .clock(clock), .reset(reset), .enabled_in(enabled_in),
        .req_valid(req_valid), .req_payload(req_payload), .req_ready(fp_req_ready),
        .credit_load(credit_load), .credit_value(credit_value),
        .cmd_valid(fp_cmd_valid), .cmd_payload(fp_cmd_payload), .cmd_tag(fp_cmd_tag),
        .cmd_channel(fp_cmd_channel), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag[1:0]),
        .rsp_credits(rsp_credits), .rsp_route(fp_rsp_route), .rsp_tag_out(fp_rsp_tag_out),
        .credit_count(fp_credit_count), .outstanding(fp_outstanding),
        .credit_overflow_error(fp_cerr), .tag_error(fp_terr));

    always #5 clock = ~clock;

    // behavioural model state, index 0 = round-robin instance, 1 = fixed-priority instance
    int m_tagw [2] = '{3, 2};
    int m_mode [2] = '{0, 1};
    bit m_in_use [2][8];
    int m_owner  [2][8];
    int m_next   [2] = '{0, 0};
    int m_last   [2] = '{3, 3};
    int m_credit [2] = '{0, 0};
    int m_outst  [2] = '{0, 0};
    bit m_terr   [2] = '{0, 0};
    bit m_cerr   [2] = '{0, 0};
    bit e_cv     [2] = '{0, 0};
    int e_pl     [2] = '{0, 0};
    int e_tag    [2] = '{0, 0};
    int e_ch     [2] = '{0, 0};
    int e_route  [2] = '{0, 0};
    int e_tagout [2] = '{0, 0};

    int rr_ch_q[$], rr_tag_q[$], fp_ch_q[$], fp_tag_q[$];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s got=%0h exp=%0h t=%0t", (k == 0) ? "rr" : "fp", name, act, exp, $time);
        end
    endtask

    // channel the spec's rules would grant right now, or -1
    function automatic int pick(input int k);
        if (!enabled_in || m_credit[k] == 0 || m_in_use[k][m_next[k]]) return -1;
        if (m_mode[k] == 1) begin
            for (int c = 0; c < 4; c++) if (req_valid[c]) return c;
        end else begin
            for (int s = 1; s <= 4; s++) begin
                int c;
                c = (m_last[k] + s) % 4;
                if (req_valid[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input int k);
        int g, t, rc, sum;
        bit hit;
        g   = pick(k);
        t   = int'(rsp_tag) % (1 << m_tagw[k]);
        rc  = int'(rsp_credits);
        if (rsp_credits[8]) rc = rc - 512;
        hit = rsp_valid && m_in_use[k][t];
        e_cv[k] = (g >= 0);
        if (g >= 0) begin
            e_pl[k]  = int'((req_payload >> (16 * g)) & 64'hffff);
            e_tag[k] = m_next[k];
            e_ch[k]  = g;
        end
        e_route[k]  = hit ? (1 << m_owner[k][t]) : 0;
        e_tagout[k] = rsp_valid ? t : 0;
        if (rsp_valid && !hit) m_terr[k] = 1'b1;
        if (credit_load) begin
            m_credit[k] = int'(credit_value);
        end else begin
            sum = m_credit[k] - ((g >= 0) ? 1 : 0) + (rsp_valid ? rc : 0);
            if (sum > 64) begin
                m_credit[k] = 64;
                m_cerr[k] = 1'b1;
            end else if (sum < 0) begin
                m_credit[k] = 0;
                m_cerr[k] = 1'b1;
            end else begin
                m_credit[k] = sum;
            end
        end
        if (g >= 0) begin
            m_in_use[k][m_next[k]] = 1'b1;
            m_owner[k][m_next[k]]  = g;
            m_next[k]  = (m_next[k] + 1) % (1 << m_tagw[k]);
            m_last[k]  = g;
            m_outst[k] = m_outst[k] + 1;
        end
        if (hit) begin
            m_in_use[k][t] = 1'b0;
            m_outst[k] = m_outst[k] - 1;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int t = 0; t < 8; t++) m_in_use[k][t] = 1'b0;
                m_next[k] = 0; m_last[k] = 3; m_credit[k] = 0; m_outst[k] = 0;
                m_terr[k] = 1'b0; m_cerr[k] = 1'b0;
                e_cv[k] = 1'b0; e_route[k] = 0; e_tagout[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic cmp_inst(input int k, input logic [3:0] ready, input logic cv,
                            input logic [15:0] pl, input logic [2:0] tag, input logic [1:0] ch,
                            input logic [3:0] route, input logic [2:0] tagout, input logic [7:0] cred,
                            input logic [3:0] outst, input logic cerr, input logic terr);
        int g;
        g = pick(k);
        chk("req_ready", k, 32'(ready), (g >= 0) ? (1 << g) : 0);
        chk("cmd_valid", k, 32'(cv), 32'(e_cv[k]));
        if (e_cv[k]) begin
            chk("cmd_payload", k, 32'(pl), e_pl[k]);
            chk("cmd_tag", k, 32'(tag), e_tag[k]);
            chk("cmd_channel", k, 32'(ch), e_ch[k]);
        end
        chk("rsp_route", k, 32'(route), e_route[k]);
        chk("rsp_tag_out", k, 32'(tagout), e_tagout[k]);
        chk("credit_count", k, 32'(cred), m_credit[k]);
        chk("outstanding", k, 32'(outst), m_outst[k]);
        chk("credit_overflow_error", k, 32'(cerr), 32'(m_cerr[k]));
        chk("tag_error", k, 32'(terr), 32'(m_terr[k]));
    endtask

    // every-cycle comparison against the model, plus issue logs for the directed checks
    always @(negedge clock) begin
        cmp_inst(0, rr_req_ready, rr_cmd_valid, rr_cmd_payload, rr_cmd_tag, rr_cmd_channel,
                 rr_rsp_route, rr_rsp_tag_out, rr_credit_count, rr_outstanding, rr_cerr, rr_terr);
        cmp_inst(1, fp_req_ready, fp_cmd_valid, fp_cmd_payload, {1'b0, fp_cmd_tag}, fp_cmd_channel,
                 fp_rsp_route, {1'b0, fp_rsp_tag_out}, fp_credit_count, {1'b0, fp_outstanding},
                 fp_cerr, fp_terr);
        if (rr_cmd_valid) begin
            rr_ch_q.push_back(int'(rr_cmd_channel));
            rr_tag_q.push_back(int'(rr_cmd_tag));
        end
        if (fp_cmd_valid) begin
            fp_ch_q.push_back(int'(fp_cmd_channel));
            fp_tag_q.push_back(int'(fp_cmd_tag));
        end
    end

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; rsp_valid = 1'b0; credit_load = 1'b0; rsp_credits = '0; rsp_tag = '0;
        tick();
        tick();
        reset = 1'b0;
        enabled_in = 1'b1;
        rr_ch_q.delete(); rr_tag_q.delete(); fp_ch_q.delete(); fp_tag_q.delete();
    endtask

    task automatic load(input int v);
        credit_load  = 1'b1;
        credit_value = 8'(v);
        tick();
        credit_load  = 1'b0;
    endtask

    task automatic respond(input int tag, input int cr);
        rsp_valid   = 1'b1;
        rsp_tag     = 3'(tag);
        rsp_credits = 9'(cr);
        tick();
        rsp_valid   = 1'b0;
        rsp_credits = '0;
    endtask

    initial begin
        // reset values
        tick();
        chk("lit_reset_credit", 0, 32'(rr_credit_count), 0);
        chk("lit_reset_cmd_valid", 0, 32'(rr_cmd_valid), 0);

        // round-robin fairness, all channels held
        do_reset();
        load(64);
        req_valid = 4'hf;
        for (int i = 0; i < 6; i++) begin
            req_payload = {$urandom(), $urandom()};
            tick();
        end
        req_valid = '0;
        tick();
        chk("lit_rr_count", 0, rr_ch_q.size(), 6);
        for (int i = 0; i < 5; i++) begin
            chk("lit_rr_channel", 0, qget(rr_ch_q, i), i % 4);
            chk("lit_rr_tag", 0, qget(rr_tag_q, i), i);
        end
        chk("lit_fp_tag_stall_count", 1, fp_ch_q.size(), 4);

        // fixed priority, channels 1 and 3
        do_reset();
        load(64);
        req_valid = 4'b1010;
        tick();
        chk("lit_fp_grant_ch1", 1, 32'(fp_req_ready), 4'b0010);
        tick();
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("lit_fp_count", 1, fp_ch_q.size(), 4);
        for (int i = 0; i < 3; i++) chk("lit_fp_ch1", 1, qget(fp_ch_q, i), 1);
        chk("lit_fp_ch3_after", 1, qget(fp_ch_q, 3), 3);

        // credit exhaustion
        do_reset();
        load(2);
        req_valid = 4'b0001;
        repeat (4) tick();
        chk("lit_exhaust_ready", 0, 32'(rr_req_ready), 0);
        chk("lit_exhaust_count", 0, rr_ch_q.size(), 2);
        respond(0, 1);
        repeat (3) tick();
        chk("lit_exhaust_refill_count", 0, rr_ch_q.size(), 3);
        chk("lit_exhaust_refill_tag", 0, qget(rr_tag_q, 2), 2);
        req_valid = '0;

        // tag wrap and stall on the 2-bit tag instance
        do_reset();
        load(64);
        req_valid = 4'b0001;
        repeat (5) tick();
        chk("lit_wrap_outstanding", 1, 32'(fp_outstanding), 4);
        chk("lit_wrap_stall_ready", 1, 32'(fp_req_ready), 0);
        respond(0, 0);
        tick();
        tick();
        req_valid = '0;
        tick();
        chk("lit_wrap_count", 1, fp_ch_q.size(), 5);
        chk("lit_wrap_tag0", 1, qget(fp_tag_q, 4), 0);
        chk("lit_wrap_outstanding_back", 1, 32'(fp_outstanding), 4);

        // routing errors and credit saturation
        do_reset();
        load(64);
        respond(5, 0);
        chk("lit_unused_tag_error", 0, 32'(rr_terr), 1);
        chk("lit_unused_tag_route", 0, 32'(rr_rsp_route), 0);
        respond(6, 3);
        chk("lit_sat_credit", 0, 32'(rr_credit_count), 64);
        chk("lit_sat_error", 0, 32'(rr_cerr), 1);

        // simultaneous issue and response at count 10
        do_reset();
        load(11);
        req_valid = 4'b0001;
        tick();
        rsp_valid = 1'b1; rsp_tag = 3'd0; rsp_credits = 9'd1;
        tick();
        rsp_valid = 1'b0; rsp_credits = '0;
        chk("lit_simul_credit", 0, 32'(rr_credit_count), 10);
        chk("lit_simul_outstanding", 0, 32'(rr_outstanding), 1);
        chk("lit_simul_route", 0, 32'(rr_rsp_route), 4'b0001);
        chk("lit_simul_tag", 0, 32'(rr_cmd_tag), 1);
        tick();
        tick();
        req_valid = '0;
        chk("lit_pre_reset_outstanding", 0, 32'(rr_outstanding), 3);
        reset = 1'b1;
        #1;
        chk("lit_mid_reset_outstanding", 0, 32'(rr_outstanding), 0);
        chk("lit_mid_reset_credit", 0, 32'(rr_credit_count), 0);
        chk("lit_mid_reset_cmd_valid", 0, 32'(rr_cmd_valid), 0);
        chk("lit_mid_reset_cmd_tag", 0, 32'(rr_cmd_tag), 0);
        chk("lit_mid_reset_route", 0, 32'(rr_rsp_route), 0);
        chk("lit_mid_reset_errors", 0, 32'({rr_cerr, rr_terr}), 0);
        tick();
        tick();
        reset = 1'b0;
        respond(0, 0);
        chk("lit_post_reset_tag_error", 0, 32'(rr_terr), 1);

        // randomized traffic
        do_reset();
        load(64);
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 399) == 0);
            enabled_in   = ($urandom_range(0, 7) != 0);
            req_valid    = 4'($urandom());
            req_payload  = {$urandom(), $urandom()};
            credit_load  = ($urandom_range(0, 63) == 0);
            credit_value = 8'($urandom_range(0, 64));
            rsp_valid    = ($urandom_range(0, 1) == 1);
            rsp_tag      = 3'($urandom());
            rsp_credits  = 9'(int'($urandom_range(0, 7)) - 3);
            tick();
        end
        reset = 1'b0; req_valid = '0; rsp_valid = 1'b0; credit_load = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/afu_command_arbiter.md
# afu_command_arbiter

Parametrised N-channel command arbiter between the compute-unit/WED command sources and the PSL command interface. It grants one request per cycle under round-robin or fixed-priority policy and gates issue on PSL credits and free tags. It records which channel owns each tag and routes each PSL response back to that channel. It generalises the fixed four-source command merge to any channel count and adds tag tracking, credit accounting and error flags.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of requesting channels (2..16)
- PAYLOAD_WIDTH, 89, opaque command payload (command code, address, size)
- TAG_WIDTH, 8, PSL tag width; tag table depth 2^TAG_WIDTH
- MAX_CREDITS, 64, credit ceiling (≤ 255)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enabled_in  in  1  job running; no issue when low
- req_valid  in  NUM_CHANNELS  per-channel request
- req_payload  in  NUM_CHANNELS×PAYLOAD_WIDTH  per-channel command, channel i at bits [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
- req_ready  out  NUM_CHANNELS  one-hot grant, combinational
- credit_load  in  1  load the credit counter
- credit_value  in  8  value loaded on credit_load
- cmd_valid  out  1  command to PSL
- cmd_payload  out  PAYLOAD_WIDTH  granted payload
- cmd_tag  out  TAG_WIDTH  allocated tag
- cmd_channel  out  $clog2(NUM_CHANNELS)  source channel
- rsp_valid  in  1  PSL response
- rsp_tag  in  TAG_WIDTH  response tag
- rsp_credits  in  9  credits returned, signed two's complement
- rsp_route  out  NUM_CHANNELS  one-hot response routing
- rsp_tag_out  out  TAG_WIDTH  echoed tag
- credit_count  out  8  available credits
- outstanding  out  TAG_WIDTH+1  tags in use
- credit_overflow_error  out  1  sticky
- tag_error  out  1  sticky

## Operation
- Issue condition: enabled_in & (credit_count > 0) & !in_use[next_tag] & |req_valid.
- When the issue condition holds, exactly one req_ready bit is asserted. The requester transfers on req_valid & req_ready.
- Round-robin: search starts at last_grant+1 modulo NUM_CHANNELS. last_grant updates only on a transfer.
- Fixed priority: the lowest-index valid channel is granted.
- On transfer:
  - The payload, next_tag and channel are registered onto cmd_*.
  - in_use[next_tag] and owner[next_tag] are set.
  - next_tag increments, wrapping at 2^TAG_WIDTH.
  - credit_count decrements.
- Tag stall: if in_use[next_tag] is set, nothing issues. Tags are never skipped; allocation order is strictly sequential.
- Response with in_use[rsp_tag] set:
  - rsp_route = one-hot of owner[rsp_tag].
  - in_use[rsp_tag] is cleared.
  - credit_count += rsp_credits.
- Response with in_use[rsp_tag] clear:
  - tag_error is set.
  - No routing and no tag change.
  - Credits are still applied.
- Credit arithmetic: computed in 10-bit signed.
  - Result > MAX_CREDITS → saturate to MAX_CREDITS and set credit_overflow_error.
  - Result < 0 → clamp to 0 and set credit_overflow_error.
- Same-cycle issue and response: net credit = count − 1 + rsp_credits. in_use is updated for both tags; if the tags are equal, the clear wins.
- credit_load takes precedence over the issue and response credit updates in that cycle. Tag updates still occur.
- enabled_in low: no new grants. Responses are still routed.

## Timing
- req_ready: combinational from req_valid and state, same cycle.
- cmd_valid / cmd_payload / cmd_tag / cmd_channel:
  - registered, valid the cycle after the transfer;
  - cmd_valid is a single-cycle pulse per transfer;
  - back-to-back transfers give back-to-back pulses.
- rsp_route / rsp_tag_out: registered, one cycle after rsp_valid; a single-cycle pulse.
- credit_count and outstanding reflect the edge on which the event is sampled.
- Reset values:
  - all outputs 0;
  - credit_count 0, so nothing issues until credit_load;
  - next_tag 0, last_grant NUM_CHANNELS−1, all in_use clear;
  - errors clear.
- Reset mid-operation: all tags are freed immediately. Responses that arrive after reset are flagged tag_error.
- Error flags are cleared only by reset.

## Test plan
- Round-robin fairness:
  - stimulus: NUM_CHANNELS=4, credit_load 64, all req_valid held;
  - required: cmd_channel sequence 0,1,2,3,0…, cmd_tag 0,1,2,3,4…
- Fixed priority (ARB_MODE=1):
  - stimulus: channels 1 and 3 valid;
  - required: channel 1 is granted every cycle and channel 3 is starved until channel 1 drops.
- Credit exhaustion:
  - stimulus: credit_load 2, single channel requesting;
  - required: two cmd_valid pulses, then req_ready stays 0;
  - stimulus: response tag 0 with rsp_credits +1;
  - required: exactly one further issue, with tag 2.
- Tag wrap and stall:
  - stimulus: TAG_WIDTH=2, 4 issues with no responses;
  - required: the 5th request stalls;
  - stimulus: response for tag 0;
  - required: next issue carries tag 0 and outstanding returns to 4.
- Routing and errors:
  - stimulus: response to an unused tag 5;
  - required: tag_error=1 and rsp_route=0;
  - stimulus: count at 64 with rsp_credits +3;
  - required: credit_count=64 and credit_overflow_error=1.
- Simultaneous events:
  - stimulus: transfer and response (+1) in the same cycle at count 10;
  - required: count stays 10 and both tag updates apply;
  - stimulus: reset asserted with 3 outstanding;
  - required: outstanding=0 and all outputs 0.
